// File: rtl/dp_mod_multi.sv
// Multi-mode (AM / FM / PM / carrier) DDS modulator: 6-clock pipeline, one sample per clock.
// Optional macro DP_MOD_PM_EN builds PM mode; without it mode 2'b10 behaves as carrier only.
module dp_mod_multi #(
    parameter int DW = 16,
    parameter int PW = 24,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          val_in,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] frec_por,
    input  logic [DW-1:0] im_am,
    input  logic [DW-1:0] im_fm,
    input  logic [DW-1:0] im_pm,
    input  logic          ph_clr,
    output logic [DW-1:0] o_data,
    output logic          val_out
);
    typedef enum logic [1:0] {
        MODE_AM  = 2'b00,
        MODE_FM  = 2'b01,
        MODE_PM  = 2'b10,
        MODE_CAR = 2'b11
    } mode_e;

    localparam int LUT_N = 2 ** LW;
    localparam int LAT   = 6;
    localparam logic signed [DW:0] ENV_BIAS = (DW+1)'(2 ** (DW - 2));

    // Signed sample times unsigned Q0.(DW-1) index, full width so nothing overflows.
    function automatic logic signed [2*DW:0] mul_su(input logic [DW-1:0] a_s, input logic [DW-1:0] b_u);
        return (2*DW+1)'(signed'(a_s)) * (2*DW+1)'(signed'({1'b0, b_u}));
    endfunction

    // Elaboration-time sine table: quarter-wave Taylor series folded by symmetry.
    function automatic logic signed [DW-1:0] sine_entry(input int k);
        int  q;
        int  mag;
        real x;
        real term;
        real sum;
        q = k % (LUT_N / 2);
        if (q > LUT_N / 4) q = LUT_N / 2 - q;
        x    = 2.0 * 3.14159265358979323846 * real'(q) / real'(LUT_N);
        term = x;
        sum  = x;
        for (int i = 1; i <= 10; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        mag = $rtoi(sum * real'(2 ** (DW - 1) - 1) + 0.5);
        return (k >= LUT_N / 2) ? DW'(-mag) : DW'(mag);
    endfunction

    logic signed [DW-1:0] sine_lut [LUT_N];

    always_comb begin
        for (int k = 0; k < LUT_N; k++) sine_lut[k] = sine_entry(k);
    end

    // Input stage: phase accumulator update
    mode_e                mode_in;
    logic signed [2*DW:0] fm_prod;
    logic [PW-1:0]        fm_dev;
    logic [PW-1:0]        phase_n;
    logic [PW-1:0]        acc_d;
    logic [PW-1:0]        acc_q;

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        mode_in = mode_e'(mode);
        fm_prod = mul_su(i_data, im_fm);
        fm_dev  = PW'(fm_prod >>> (DW - 1)) << (PW - DW);
        phase_n = ph_clr ? '0 : acc_q;
        acc_d   = acc_q;
        if (val_in) begin
            acc_d = phase_n + frec_por + ((mode_in == MODE_FM) ? fm_dev : '0);
        end else if (ph_clr) begin
            acc_d = '0;
        end
    end

    // Pipeline registers
    logic [LAT-1:0]        vld_q;
    logic [DW-1:0]         o_data_q;
    logic [DW-1:0]         data1_q;
    logic [DW-1:0]         am1_q;
    logic [PW-1:0]         ph1_q;
    logic                  is_am1_q;
    logic signed [DW:0]    env2_d;
    logic signed [DW:0]    env2_q;
    logic [PW-1:0]         look2_d;
    logic [PW-1:0]         look2_q;
    logic                  is_am2_q;
    logic [LW-1:0]         lut_addr;
    logic signed [DW-1:0]  sin3_q;
    logic signed [DW:0]    env3_q;
    logic                  is_am3_q;
    logic signed [2*DW:0]  prod4_q;
    logic signed [DW-1:0]  sin4_q;
    logic                  is_am4_q;
    logic signed [DW-1:0]  res5_q;

`ifdef DP_MOD_PM_EN
    logic [DW-1:0] pm1_q;
    logic          is_pm1_q;
`else
    logic unused_im_pm;
    assign unused_im_pm = ^im_pm;
`endif

    always_comb begin
        env2_d  = ENV_BIAS + (DW+1)'(mul_su(data1_q, am1_q) >>> DW);
        look2_d = ph1_q;
`ifdef DP_MOD_PM_EN
        if (is_pm1_q) begin
            look2_d = ph1_q + (PW'(mul_su(data1_q, pm1_q) >>> (DW - 1)) << (PW - DW));
        end
`endif
        lut_addr = LW'(look2_q >> (PW - LW));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            acc_q    <= '0;
            o_data_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], val_in};
            acc_q <= acc_d;
            if (vld_q[LAT-2]) o_data_q <= res5_q;
        end
    end

    // NOTE: datapath registers carry no reset; the valid chain alone decides what is ever seen.
    always_ff @(posedge clk) begin
        if (val_in) begin
            data1_q  <= i_data;
            am1_q    <= im_am;
            ph1_q    <= phase_n;
            is_am1_q <= (mode_in == MODE_AM);
`ifdef DP_MOD_PM_EN
            pm1_q    <= im_pm;
            is_pm1_q <= (mode_in == MODE_PM);
`endif
        end
        env2_q   <= env2_d;
        look2_q  <= look2_d;
        is_am2_q <= is_am1_q;
        sin3_q   <= sine_lut[lut_addr];
        env3_q   <= env2_q;
        is_am3_q <= is_am2_q;
        prod4_q  <= (2*DW+1)'(sin3_q) * (2*DW+1)'(env3_q);
        sin4_q   <= sin3_q;
        is_am4_q <= is_am3_q;
        res5_q   <= is_am4_q ? DW'(prod4_q >>> (DW - 1)) : sin4_q;
    end

    assign o_data  = o_data_q;
    assign val_out = vld_q[LAT-1];

endmodule

// File: tb/tb_dp_mod_multi.sv
// Scoreboard bench for dp_mod_multi: driver pushes model expectations, negedge monitor pops and compares.
module tb_dp_mod_multi;
    localparam int     DW    = 16;
    localparam int     PW    = 24;
    localparam int     LW    = 10;
    localparam int     LUT_N = 1 << LW;
    localparam longint PMASK = (longint'(1) << PW) - 1;
    localparam int     F_Q   = 1 << 22;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_data;
    logic          val_in;
    logic [1:0]    mode;
    logic [PW-1:0] frec_por;
    logic [DW-1:0] im_am;
    logic [DW-1:0] im_fm;
    logic [DW-1:0] im_pm;
    logic          ph_clr;
    logic [DW-1:0] o_data;
    logic          val_out;

    dp_mod_multi #(.DW(DW), .PW(PW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .val_in(val_in), .mode(mode),
        .frec_por(frec_por), .im_am(im_am), .im_fm(im_fm), .im_pm(im_pm),
        .ph_clr(ph_clr), .o_data(o_data), .val_out(val_out)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int issue; } exp_t;
    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     last_exp = 0;
    int     sine_tab [LUT_N];
    longint acc_m    = 0;
    int     quad_seq [4];
    int     half_seq [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every val_out pops one expectation; idle cycles must hold the last output.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1) begin
            if (val_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_val_out", val_out, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("o_data_known", $isunknown(o_data), 0);
                    check("o_data", $signed(o_data), e.val);
                    check("latency", cyc - e.issue, 6);
                    last_exp = e.val;
                end
            end else begin
                check("hold_o_data", $signed(o_data), last_exp);
            end
        end
    end

    task automatic set_garbage();
        i_data   = DW'($urandom);
        mode     = 2'($urandom);
        frec_por = PW'($urandom);
        im_am    = DW'($urandom);
        im_fm    = DW'($urandom);
        im_pm    = DW'($urandom);
    endtask

    task automatic idle(input bit clr);
        set_garbage();
        val_in = 1'b0;
        ph_clr = clr;
        if (clr) acc_m = 0;
        @(posedge clk);
        #1;
        ph_clr = 1'b0;
    endtask

    // Reference model: phase accumulator and output computed straight from the arithmetic rules.
    task automatic send(input int data, input int md, input int frec, input int am, input int fm,
                        input int pm, input bit clr, input bit use_lit, input int lit);
        longint p;
        longint inc;
        longint look;
        int     s;
        int     env;
        int     res;
        exp_t   e;
        p   = clr ? 0 : acc_m;
        inc = frec;
        if (md == 1) inc += ((longint'(data) * fm) >>> (DW - 1)) << (PW - DW);
        acc_m = (p + inc) & PMASK;
        look  = p;
`ifdef DP_MOD_PM_EN
        if (md == 2) look = (p + (((longint'(data) * pm) >>> (DW - 1)) << (PW - DW))) & PMASK;
`endif
        s = sine_tab[look >> (PW - LW)];
        if (md == 0) begin
            env = (1 << (DW - 2)) + int'((longint'(data) * am) >>> DW);
            res = int'((longint'(s) * env) >>> (DW - 1));
        end else begin
            res = s;
        end
        i_data   = DW'(data);
        mode     = 2'(md);
        frec_por = PW'(frec);
        im_am    = DW'(am);
        im_fm    = DW'(fm);
        im_pm    = DW'(pm);
        ph_clr   = clr;
        val_in   = 1'b1;
        e.val    = use_lit ? lit : res;
        e.issue  = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        val_in = 1'b0;
        ph_clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_outstanding", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < LUT_N; k++) begin
            real r;
            r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N));
            sine_tab[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        end
        quad_seq = '{0, 32767, 0, -32767};
        half_seq = '{0, 16383, 0, -16384};

        rst    = 1'b0;
        val_in = 1'b0;
        ph_clr = 1'b0;
        set_garbage();
        repeat (2) @(posedge clk);
        #1;
        check("reset_val_out", val_out, 0);
        check("reset_o_data", $signed(o_data), 0);
        rst = 1'b1;
        idle(0);
        idle(0);

        // Carrier, continuous input
        for (int i = 0; i < 12; i++) send(int'($urandom_range(0, 65535)) - 32768, 3, F_Q, 0, 0, 0, i == 0, 1, quad_seq[i % 4]);
        drain();

        // Carrier, one sample every third clock
        for (int i = 0; i < 8; i++) begin
            send(0, 3, F_Q, 0, 0, 0, i == 0, 1, quad_seq[i % 4]);
            idle(0);
            idle(0);
        end
        drain();

        // AM with zero index gives half-scale carrier
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 65535)) - 32768, 0, F_Q, 0, 0, 0, i == 0, 1, half_seq[i % 4]);
        // AM at the index and sample extremes
        for (int i = 0; i < 4; i++) send(-32768, 0, F_Q, 32767, 0, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) send(32767, 0, F_Q, 32767, 0, 0, 1'b0, 1'b0, 0);
        drain();

        // FM with zero carrier: the deviation alone drives the phase
        for (int i = 0; i < 8; i++) send(16384, 1, 0, 0, 32767, 0, i == 0, 1'b0, 0);
        drain();

        // PM with zero carrier: constant offset near the positive peak, or zero when PM is not built
        for (int i = 0; i < 6; i++) send(16384, 2, 0, 0, 0, 32767, i == 0, 1'b0, 0);
        drain();

        // Reset with three samples in flight: they are discarded and the phase restarts at zero
        for (int i = 0; i < 3; i++) send(0, 3, F_Q, 0, 0, 0, i == 0, 1'b0, 0);
        idle(0);
        rst = 1'b0;
        #2;
        check("midrst_val_out", val_out, 0);
        check("midrst_o_data", $signed(o_data), 0);
        sb_q.delete();
        acc_m    = 0;
        last_exp = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) idle(0);
        for (int i = 0; i < 8; i++) send(0, 3, F_Q, 0, 0, 0, 1'b0, 1, quad_seq[i % 4]);
        drain();

        // Randomised traffic: all modes, random gaps, occasional clears with and without a sample
        for (int i = 0; i < 400; i++) begin
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, (1 << PW) - 1)), int'($urandom_range(0, 32767)),
                 int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)),
                 $urandom_range(0, 15) == 0, 1'b0, 0);
            repeat ($urandom_range(0, 2)) idle($urandom_range(0, 7) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
